video_timing_gen: RTL

//  Raster timing source upstream of the Ibniz adapter/generator array.
//  - Scans pixel coordinates; drives iX_video/iY_video and the endFrame pulse consumed there.
//  - Produces hsync/vsync/de for the display.
//  - Optional clk-cycle delay line realigns sync/de with the adapter's registered RGB output.

---
 rtl/video_timing_pkg.sv | 40 ++++
 rtl/sync_delay_line.sv | 32 +++
 rtl/video_timing_gen.sv | 116 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared timing constants and phase encoding for the raster generator.
// Default mode is 1280x1024; a 640x480 set is kept for the low-res mode.
package video_timing_pkg;

  localparam int SXGA_H_ACTIVE = 1280;
  localparam int SXGA_H_FP     = 48;
  localparam int SXGA_H_SYNC   = 112;
  localparam int SXGA_H_BP     = 248;
  localparam int SXGA_V_ACTIVE = 1024;
  localparam int SXGA_V_FP     = 1;
  localparam int SXGA_V_SYNC   = 3;
  localparam int SXGA_V_BP     = 38;

  localparam int H_TOTAL = SXGA_H_ACTIVE + SXGA_H_FP
                         + SXGA_H_SYNC + SXGA_H_BP;
  localparam int V_TOTAL = SXGA_V_ACTIVE + SXGA_V_FP
                         + SXGA_V_SYNC + SXGA_V_BP;

  localparam int H_SYNC_START = SXGA_H_ACTIVE + SXGA_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + SXGA_H_SYNC;
  localparam int V_SYNC_START = SXGA_V_ACTIVE + SXGA_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + SXGA_V_SYNC;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    ACTIVE,
    FP,
    SYNC,
    BP
  } phase_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register for {hsync, vsync, de}.
// Shifts every clk; DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int         DEPTH   = 1,
  parameter logic [2:0] RST_VAL = 3'b001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_pipe
    logic [2:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster scan counters, horizontal/vertical phase FSMs and sync outputs.
// Sync/de are registered from next-state values so they track oX/oY.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = SXGA_H_ACTIVE,
  parameter int   H_FP       = SXGA_H_FP,
  parameter int   H_SYNC     = SXGA_H_SYNC,
  parameter int   H_BP       = SXGA_H_BP,
  parameter int   V_ACTIVE   = SXGA_V_ACTIVE,
  parameter int   V_FP       = SXGA_V_FP,
  parameter int   V_SYNC     = SXGA_V_SYNC,
  parameter int   V_BP       = SXGA_V_BP,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   PIPE_DELAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic signed [11:0] oX_video,
  output logic signed [11:0] oY_video,
  output logic               oEndFrame,
  output logic               oHsync,
  output logic               oVsync,
  output logic               oDe,
  output logic               oHsync_d,
  output logic               oVsync_d,
  output logic               oDe_d
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(HT - 1);
  localparam logic [10:0] H_FP_AT = 11'(H_ACTIVE);
  localparam logic [10:0] H_SY_AT = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_AT = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST  = 11'(VT - 1);
  localparam logic [10:0] V_FP_AT = 11'(V_ACTIVE);
  localparam logic [10:0] V_SY_AT = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_AT = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h, v, h_nxt, v_nxt;
  phase_t      hp, vp, hp_nxt, vp_nxt;
  logic        h_wrap, v_wrap;
  logic        hs_q, vs_q, de_q;
  logic [2:0]  sync_d;

  always_comb begin
    h_nxt  = h;
    v_nxt  = v;
    hp_nxt = hp;
    vp_nxt = vp;
    h_wrap = (h == H_LAST);
    v_wrap = (v == V_LAST);
    if (ce) begin
      h_nxt = h_wrap ? '0 : h + 11'd1;
      unique case (hp)
        ACTIVE: if (h_nxt == H_FP_AT) hp_nxt = FP;
        FP:     if (h_nxt == H_SY_AT) hp_nxt = SYNC;
        SYNC:   if (h_nxt == H_BP_AT) hp_nxt = BP;
        BP:     if (h_wrap)           hp_nxt = ACTIVE;
      endcase
      if (h_wrap) begin
        v_nxt = v_wrap ? '0 : v + 11'd1;
        unique case (vp)
          ACTIVE: if (v_nxt == V_FP_AT) vp_nxt = FP;
          FP:     if (v_nxt == V_SY_AT) vp_nxt = SYNC;
          SYNC:   if (v_nxt == V_BP_AT) vp_nxt = BP;
          BP:     if (v_wrap)           vp_nxt = ACTIVE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h    <= '0;
      v    <= '0;
      hp   <= ACTIVE;
      vp   <= ACTIVE;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b1;
    end else begin
      h    <= h_nxt;
      v    <= v_nxt;
      hp   <= hp_nxt;
      vp   <= vp_nxt;
      hs_q <= (hp_nxt == SYNC) ? HS_POL : ~HS_POL;
      vs_q <= (vp_nxt == SYNC) ? VS_POL : ~VS_POL;
      de_q <= (hp_nxt == ACTIVE) && (vp_nxt == ACTIVE);
    end
  end

  assign oX_video  = signed'({1'b0, h});
  assign oY_video  = signed'({1'b0, v});
  assign oEndFrame = ce && h_wrap && v_wrap;
  assign oHsync    = hs_q;
  assign oVsync    = vs_q;
  assign oDe       = de_q;

  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b1})
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .d   ({hs_q, vs_q, de_q}),
    .q   (sync_d)
  );

  assign {oHsync_d, oVsync_d, oDe_d} = sync_d;

endmodule
